// File: rtl/imm_gen_pipe_pkg.sv
// Shared constants for the immediate generator: format select codes and
// output-stage occupancy encoding.
package imm_pkg;

    localparam int IMM_SRC_W = 3;

    localparam logic [IMM_SRC_W-1:0] IMM_I = 3'b000;
    localparam logic [IMM_SRC_W-1:0] IMM_S = 3'b001;
    localparam logic [IMM_SRC_W-1:0] IMM_B = 3'b010;
    localparam logic [IMM_SRC_W-1:0] IMM_U = 3'b011;
    localparam logic [IMM_SRC_W-1:0] IMM_J = 3'b100;
    localparam logic [IMM_SRC_W-1:0] IMM_Z = 3'b101;

    // Occupancy of the output register + skid register pair.
    typedef logic [1:0] occ_t;
    localparam occ_t OCC_EMPTY = 2'd0;
    localparam occ_t OCC_ONE   = 2'd1;
    localparam occ_t OCC_TWO   = 2'd2;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle between decode (upstream), the immediate generator and
// execute (downstream). slave = the generator's view, master = environment.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32,
    parameter int CNT_W = 8
) ();
    import imm_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_ins;
    logic [IMM_SRC_W-1:0] in_imm_src;
    logic [TAG_W-1:0]     in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      out_imm;
    logic [TAG_W-1:0]     out_tag;
    logic                 out_fmt_err;
    logic [CNT_W-1:0]     err_count;

    modport slave (
        input  in_valid, in_ins, in_imm_src, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_fmt_err, err_count
    );

    modport master (
        output in_valid, in_ins, in_imm_src, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_fmt_err, err_count
    );

endinterface

// File: rtl/imm_gen_pipe_decode.sv
// Combinational immediate decoder: {ins, imm_src} -> {imm, fmt_err}.
// Optional feature macro: IMM_GEN_CSR_ZIMM_EN enables code 101 as the
// zero-extended CSR*I uimm (Ins[19:15]); otherwise 101 is unsupported.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]          ins,
    input  logic [IMM_SRC_W-1:0] imm_src,
    output logic [XLEN-1:0]      imm,
    output logic                 fmt_err
);

    logic [31:0] imm32;
    logic        zext;
    logic        unused_opcode;

    // Opcode bits never feed any immediate field.
    assign unused_opcode = ^ins[6:0];

    // Assemble the 32-bit immediate; widening to XLEN happens afterwards.
    always_comb begin
        imm32   = {{20{ins[31]}}, ins[31:20]};
        fmt_err = 1'b0;
        zext    = 1'b0;
        case (imm_src)
            IMM_I: imm32 = {{20{ins[31]}}, ins[31:20]};
            IMM_S: imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B: imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U: imm32 = {ins[31:12], 12'b0};
            IMM_J: imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
`ifdef IMM_GEN_CSR_ZIMM_EN
            IMM_Z: begin
                imm32 = {27'b0, ins[19:15]};
                zext  = 1'b1;
            end
`endif
            default: begin
                imm32   = {{20{ins[31]}}, ins[31:20]};
                fmt_err = 1'b1;
            end
        endcase
    end

    // Widen to XLEN: Z-type is zero-extended, everything else sign-extended.
    always_comb begin
        if (zext) imm = XLEN'(imm32);
        else      imm = XLEN'($signed(imm32));
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with a 2-entry (output + skid) buffer.
// Optional feature macro: IMM_GEN_CSR_ZIMM_EN (see imm_decode).
// in_ready is registered so there is no combinational path from out_ready.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32,
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    imm_gen_pipe_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [XLEN-1:0]  dec_imm;
    logic             dec_err;

    occ_t             state_q, state_d;
    logic             in_ready_q;
    logic [XLEN-1:0]  out_imm_q;
    logic [TAG_W-1:0] out_tag_q;
    logic             out_err_q;
    logic [XLEN-1:0]  skid_imm_q;
    logic [TAG_W-1:0] skid_tag_q;
    logic             skid_err_q;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic             acc, drain;
    logic             load_out_new, load_out_skid, load_skid;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .ins     (bus.in_ins),
        .imm_src (bus.in_imm_src),
        .imm     (dec_imm),
        .fmt_err (dec_err)
    );

    assign acc   = bus.in_valid & in_ready_q;
    assign drain = (state_q != OCC_EMPTY) & bus.out_ready;

    // Occupancy transitions and which register loads from where.
    always_comb begin
        state_d       = state_q;
        load_out_new  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state_q)
            OCC_EMPTY: begin
                if (acc) begin
                    state_d      = OCC_ONE;
                    load_out_new = 1'b1;
                end
            end
            OCC_ONE: begin
                if (acc && !drain) begin
                    state_d   = OCC_TWO;
                    load_skid = 1'b1;
                end else if (drain && !acc) begin
                    state_d = OCC_EMPTY;
                end else if (acc && drain) begin
                    load_out_new = 1'b1;
                end
            end
            OCC_TWO: begin
                if (drain) begin
                    state_d       = OCC_ONE;
                    load_out_skid = 1'b1;
                end
            end
            default: state_d = OCC_EMPTY;
        endcase
    end

    // Saturating count of accepted words flagged with a format error.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (acc && dec_err && (err_cnt_q != CNT_MAX)) err_cnt_d = err_cnt_q + 1'b1;
    end

    // Occupancy state and the registered ready derived from next occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= OCC_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != OCC_TWO);
        end
    end

    // Output register: loads a fresh word directly or promotes the skid entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_imm_q <= '0;
            out_tag_q <= '0;
            out_err_q <= 1'b0;
        end else if (load_out_new) begin
            out_imm_q <= dec_imm;
            out_tag_q <= bus.in_tag;
            out_err_q <= dec_err;
        end else if (load_out_skid) begin
            out_imm_q <= skid_imm_q;
            out_tag_q <= skid_tag_q;
            out_err_q <= skid_err_q;
        end
    end

    // Skid register: holds the younger word while the output is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_imm_q <= '0;
            skid_tag_q <= '0;
            skid_err_q <= 1'b0;
        end else if (load_skid) begin
            skid_imm_q <= dec_imm;
            skid_tag_q <= bus.in_tag;
            skid_err_q <= dec_err;
        end
    end

    // Error counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = (state_q != OCC_EMPTY);
    assign bus.out_imm     = out_imm_q;
    assign bus.out_tag     = out_tag_q;
    assign bus.out_fmt_err = out_err_q;
    assign bus.err_count   = err_cnt_q;

endmodule
